pkt_injector: RTL
=================

Name: pkt_injector

Overview:
- Traffic source attached to a router's Local input port; the transmit-side counterpart of the per-node collector sink.
- Builds 26-bit packets carrying PacketID, SenderID (own router ID), destination ID and payload, and pushes them into the router with the Req/Gnt/Full local-port handshake.
- Destinations are walked round-robin over the mesh, skipping itself.

Parameters:
- routerID, 6'b000_000, own node ID {row[2:0], col[2:0]}; driven as SenderID.
- packetwidth, 26, packet bus width.
- MESH_DIM, 3, mesh rows = mesh columns.
- NUM_PACKETS, 16, packets to send before done; 0 = unlimited.
- INJ_GAP, 0, idle cycles inserted after each packet release.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  allow injection of new packets.
- DnStrFull  in  1  router local input buffer full.
- GntDnStr  in  1  router grant; packet accepted.
- ReqDnStr  out  1  request to router.
- PacketOut  out  packetwidth  packet to router local port.
- sent_count  out  10  packets granted since reset.
- done  out  1  NUM_PACKETS reached.
- stall_cycles  out  16  see Optional Feature.

Behaviour:
- Reset is asynchronous, active-low; clock is clk. On reset: ReqDnStr=0, PacketOut=0, sent_count=0, done=0, stall_cycles=0, PacketID=0, dest=first valid dest, state=IDLE. A mid-handshake reset drops ReqDnStr immediately.
- Packet format:
  - [25] = 0
  - [24:15] = PacketID
  - [14:9] = routerID
  - [8:3] = DestID
  - [2:0] = PacketID[2:0] (payload check bits)
- Dest walk: increment col, then row, wrapping at MESH_DIM; skip routerID. With routerID=000_000 and MESH_DIM=3: 000_001, 000_010, 001_000 … 010_010, then back to 000_001.
- FSM states:
  - IDLE: if enable && !done && !DnStrFull, go to REQ next edge; load PacketOut and set ReqDnStr=1 on the same edge. Otherwise hold, with ReqDnStr=0.
  - REQ: hold ReqDnStr=1 and PacketOut stable regardless of DnStrFull or enable (no withdrawal). On GntDnStr=1: ReqDnStr<=0, PacketID+1 (10-bit wrap 1023→0), sent_count+1 (wraps), advance dest, go to RELEASE.
  - RELEASE: ReqDnStr=0 for one cycle. If NUM_PACKETS!=0 && sent_count==NUM_PACKETS: go to DONE. Else if INJ_GAP==0: go to IDLE. Else go to GAP.
  - GAP: exactly INJ_GAP cycles with ReqDnStr=0, then IDLE.
  - DONE: done=1, ReqDnStr=0; exits only on reset.
- Timing guarantees: ReqDnStr drops on the edge after GntDnStr is sampled high. A sink that samples on Req and pulses Gnt for one cycle therefore never double-captures.
- Throughput: INJ_GAP=0 with an immediate-grant sink gives one packet per 4 cycles.
- Simultaneous events: DnStrFull rising in the same cycle as the IDLE→REQ decision uses the sampled value (Full=1 → stay IDLE). If enable falls during REQ, the handshake completes, then the FSM parks in IDLE.

Optional Feature:
- Macro: PKTGEN_STALL_CNT_EN.
- Defined: stall_cycles increments every cycle in REQ with GntDnStr=0, and every cycle in IDLE with enable=1, done=0 and DnStrFull=1. It saturates at 16'hFFFF and clears only on reset.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Ideal sink (Gnt one cycle after Req, then Gnt=0), NUM_PACKETS=3, INJ_GAP=0, routerID=000_000 → 3 packets with PacketID 0,1,2 and DestID 000_001, 000_010, 001_000; Req rises every 4 cycles; done=1 and sent_count=3 after RELEASE of the third packet.
- DnStrFull=1 for 10 cycles with enable=1 → ReqDnStr stays 0; Full falls → ReqDnStr=1 on the next edge; stall_cycles=10 (macro on).
- Gnt held off 5 cycles after Req → ReqDnStr and PacketOut stable for all 5 cycles; Req drops the edge after Gnt; stall_cycles=5 (macro on, 0 off).
- INJ_GAP=3 → exactly 1 (RELEASE) + 3 (GAP) + 1 (IDLE) low cycles between consecutive Req pulses.
- Reset asserted during REQ → ReqDnStr=0 asynchronously; after release the first packet has PacketID=0 and DestID=000_001.
- NUM_PACKETS=0, 1030 grants → PacketID wraps 1023→0 at packet 1024; DestID repeats with period 8; done stays 0.

Source files
------------

// File: rtl/pkt_injector.sv
// pkt_injector: local-port traffic source, round-robin destinations.
// Optional stall counter built when PKTGEN_STALL_CNT_EN is defined.
module pkt_injector #(
  parameter logic [5:0] routerID    = 6'b000_000,
  parameter int         packetwidth = 26,
  parameter int         MESH_DIM    = 3,
  parameter int         NUM_PACKETS = 16,
  parameter int         INJ_GAP     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   DnStrFull,
  input  logic                   GntDnStr,
  output logic                   ReqDnStr,
  output logic [packetwidth-1:0] PacketOut,
  output logic [9:0]             sent_count,
  output logic                   done,
  output logic [15:0]            stall_cycles
);

  typedef enum logic [2:0] {
    IDLE, REQ, RELEASE, GAP, DONE
  } state_t;

  localparam logic [2:0] DIM_M1 = 3'(MESH_DIM - 1);
  localparam logic [9:0] NUM_P  = 10'(NUM_PACKETS);
  localparam logic [15:0] GAP_M1 =
    (INJ_GAP > 0) ? 16'(INJ_GAP - 1) : 16'd0;

  function automatic logic [5:0] step(
    input logic [5:0] d
  );
    logic [2:0] r;
    logic [2:0] c;
    r = d[5:3];
    c = d[2:0];
    if (c == DIM_M1) begin
      c = 3'd0;
      r = (r == DIM_M1) ? 3'd0 : r + 3'd1;
    end else begin
      c = c + 3'd1;
    end
    return {r, c};
  endfunction

  function automatic logic [5:0] next_dest(
    input logic [5:0] d
  );
    logic [5:0] n;
    n = step(d);
    if (n == routerID) n = step(n);
    return n;
  endfunction

  localparam logic [5:0] FIRST_DEST = next_dest(routerID);

  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  logic [packetwidth-1:0] pkt_q, pkt_d;
  logic [9:0]             pid_q, pid_d;
  logic [9:0]             cnt_q, cnt_d;
  logic [5:0]             dest_q, dest_d;
  logic [15:0]            gap_q, gap_d;

  // Handshake FSM: next state, packet build, counters.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pkt_d   = pkt_q;
    pid_d   = pid_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (enable && !DnStrFull) begin
          state_d = REQ;
          req_d   = 1'b1;
          pkt_d   = packetwidth'({1'b0, pid_q, routerID,
                                  dest_q, pid_q[2:0]});
        end
      end
      REQ: begin
        if (GntDnStr) begin
          state_d = RELEASE;
          req_d   = 1'b0;
          pid_d   = pid_q + 10'd1;
          cnt_d   = cnt_q + 10'd1;
          dest_d  = next_dest(dest_q);
        end
      end
      RELEASE: begin
        if (NUM_PACKETS != 0 && cnt_q == NUM_P) begin
          state_d = DONE;
        end else if (INJ_GAP == 0) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
          gap_d   = GAP_M1;
        end
      end
      GAP: begin
        if (gap_q == 16'd0) state_d = IDLE;
        else gap_d = gap_q - 16'd1;
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      pkt_q   <= '0;
      pid_q   <= '0;
      cnt_q   <= '0;
      dest_q  <= FIRST_DEST;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pkt_q   <= pkt_d;
      pid_q   <= pid_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      gap_q   <= gap_d;
    end
  end

  assign ReqDnStr   = req_q;
  assign PacketOut  = pkt_q;
  assign sent_count = cnt_q;
  assign done       = (state_q == DONE);

`ifdef PKTGEN_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  logic        stall_hit;

  // Saturating count of blocked request/issue cycles.
  always_comb begin
    stall_hit = (state_q == REQ && !GntDnStr)
             || (state_q == IDLE && enable && DnStrFull);
    stall_d = stall_q;
    if (stall_hit && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule
